// File: rtl/new_operand_buffer.sv
// rtl/new_operand_buffer.sv - keypad/ALU operand register with sign and seven-segment ones-digit outputs
module new_operand_buffer (
    input  logic       clk,
    input  logic       nrst,
    input  logic [8:0] result,
    input  logic       result_ready,
    input  logic       enter,
    input  logic       store_digit,
    input  logic [3:0] digit,
    output logic [8:0] op1,
    output logic       sign,
    output logic [7:0] ssdec
);

    logic [8:0] op1_next;

    // Fixed priority: ALU result, then clear, then keypad shift. Lower requests are dropped.
    always_comb begin
        op1_next = op1;
        if (result_ready) begin
            op1_next = result;
        end else if (enter) begin
            op1_next = 9'b0;
        end else if (store_digit && (digit <= 4'd9)) begin
            op1_next = {op1[8], op1[3:0], digit};
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            op1 <= 9'b0;
        end else begin
            op1 <= op1_next;
        end
    end

    assign sign = op1[8];

    // Active-high {dp,g,f,e,d,c,b,a}; non-decimal nibbles blank the display.
    always_comb begin
        ssdec = 8'h00;
        case (op1[3:0])
            4'd0:    ssdec = 8'h3F;
            4'd1:    ssdec = 8'h06;
            4'd2:    ssdec = 8'h5B;
            4'd3:    ssdec = 8'h4F;
            4'd4:    ssdec = 8'h66;
            4'd5:    ssdec = 8'h6D;
            4'd6:    ssdec = 8'h7D;
            4'd7:    ssdec = 8'h07;
            4'd8:    ssdec = 8'h7F;
            4'd9:    ssdec = 8'h6F;
            default: ssdec = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_new_operand_buffer.sv
// tb/tb_new_operand_buffer.sv - directed scoreboard bench for new_operand_buffer
module tb_new_operand_buffer;

    logic       tb_clk = 1'b0;
    logic       nrst;
    logic [8:0] result;
    logic       result_ready;
    logic       enter;
    logic       store_digit;
    logic [3:0] digit;
    logic [8:0] op1;
    logic       sign;
    logic [7:0] ssdec;

    int passed = 0;
    int total  = 0;

    logic [8:0] model_op1;
    logic [8:0] sb [$];

    localparam logic [7:0] SEG [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    new_operand_buffer dut (
        .clk          (tb_clk),
        .nrst         (nrst),
        .result       (result),
        .result_ready (result_ready),
        .enter        (enter),
        .store_digit  (store_digit),
        .digit        (digit),
        .op1          (op1),
        .sign         (sign),
        .ssdec        (ssdec)
    );

    always #5 tb_clk = ~tb_clk;

    task automatic check_head(input string tag);
        logic [8:0] e;
        logic [7:0] e_seg;
        total++;
        assert (sb.size() != 0) passed++;
        else $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
        if (sb.size() != 0) begin
            e     = sb.pop_front();
            e_seg = SEG[e[3:0]];
            total++;
            assert (op1 === e) passed++;
            else $error("FAIL %s op1 observed=%h expected=%h", tag, op1, e);
            total++;
            assert (sign === e[8]) passed++;
            else $error("FAIL %s sign observed=%b expected=%b", tag, sign, e[8]);
            total++;
            assert (ssdec === e_seg) passed++;
            else $error("FAIL %s ssdec observed=%h expected=%h", tag, ssdec, e_seg);
        end
    endtask

    // Apply controls at a falling edge, predict, then check at the next falling edge.
    task automatic step(input logic rr, input logic [8:0] res, input logic en,
                        input logic sd, input logic [3:0] dg, input string tag);
        result_ready = rr;
        result       = res;
        enter        = en;
        store_digit  = sd;
        digit        = dg;
        if (rr)                      model_op1 = res;
        else if (en)                 model_op1 = 9'b0;
        else if (sd && dg <= 4'd9)   model_op1 = {model_op1[8], model_op1[3:0], dg};
        sb.push_back(model_op1);
        @(negedge tb_clk);
        check_head(tag);
    endtask

    initial begin
        nrst         = 1'b0;
        result       = 9'h1FF;
        result_ready = 1'b1;
        enter        = 1'b0;
        store_digit  = 1'b1;
        digit        = 4'd5;
        model_op1    = 9'b0;

        // Reset held two cycles with inputs active; they must be ignored.
        @(negedge tb_clk);
        @(negedge tb_clk);
        sb.push_back(9'b0);
        check_head("reset_hold");
        nrst = 1'b1;
        step(1'b0, 9'h000, 1'b0, 1'b0, 4'd0, "reset_release");

        step(1'b1, 9'b100110010, 1'b0, 1'b0, 4'd0, "load_neg32");
        step(1'b0, 9'h000,       1'b1, 1'b0, 4'd0, "enter_clear");
        step(1'b0, 9'h000,       1'b1, 1'b0, 4'd0, "enter_on_zero");
        step(1'b1, 9'h032,       1'b0, 1'b0, 4'd0, "preload_32");
        step(1'b0, 9'h000,       1'b1, 1'b0, 4'd0, "enter_after_32");

        step(1'b0, 9'h000, 1'b0, 1'b1, 4'd1, "digit1_first");
        step(1'b0, 9'h000, 1'b0, 1'b1, 4'd1, "digit1_second");
        step(1'b0, 9'h000, 1'b0, 1'b1, 4'd1, "digit1_hold");
        step(1'b0, 9'h000, 1'b0, 1'b0, 4'd1, "idle_hold_11");

        step(1'b0, 9'h000, 1'b1, 1'b0, 4'd0, "clear_again");
        step(1'b0, 9'h000, 1'b0, 1'b0, 4'd0, "idle_zero_a");
        step(1'b0, 9'h000, 1'b0, 1'b0, 4'd0, "idle_zero_b");
        step(1'b0, 9'h000, 1'b0, 1'b1, 4'hA, "digitA_ignored");
        step(1'b0, 9'h000, 1'b0, 1'b1, 4'd9, "digit9_boundary");
        step(1'b0, 9'h000, 1'b0, 1'b1, 4'hF, "digitF_ignored");

        step(1'b1, 9'h045, 1'b1, 1'b0, 4'd0, "rr_beats_enter");
        step(1'b1, 9'h145, 1'b0, 1'b0, 4'd0, "load_145");
        step(1'b0, 9'h000, 1'b0, 1'b1, 4'd7, "store7_keep_sign");
        step(1'b0, 9'h000, 1'b1, 1'b1, 4'd3, "enter_beats_store");
        step(1'b1, 9'h0AB, 1'b1, 1'b1, 4'd2, "rr_beats_all_raw");
        step(1'b0, 9'h000, 1'b0, 1'b1, 4'd4, "store_after_raw");

        // Asynchronous reset between edges discards a partial operand.
        step(1'b0, 9'h000, 1'b0, 1'b1, 4'd3, "partial_entry");
        result_ready = 1'b1;
        result       = 9'h1FF;
        #2;
        nrst = 1'b0;
        #1;
        model_op1 = 9'b0;
        sb.push_back(9'b0);
        check_head("async_reset_now");
        @(posedge tb_clk);
        #1;
        sb.push_back(9'b0);
        check_head("reset_ignores_rr");
        @(negedge tb_clk);
        nrst = 1'b1;
        step(1'b0, 9'h000, 1'b0, 1'b0, 4'd0, "post_reset_idle");
        step(1'b0, 9'h000, 1'b0, 1'b1, 4'd8, "post_reset_store8");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/new_operand_buffer.md
NEW_OPERAND_BUFFER -- requirements
Module: new_operand_buffer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; clock port `clk`, reset port `nrst`.
REQ-002 The ports SHALL be (name  direction  width  meaning):
- clk  input  1  system clock, rising-edge active.
- nrst  input  1  asynchronous active-low reset.
- result  input  9  signed-magnitude BCD value from the ALU: bit 8 sign, bits 7:4 tens, bits 3:0 ones.
- result_ready  input  1  load `result` into the buffer.
- enter  input  1  clear the buffer for a new operand.
- store_digit  input  1  shift `digit` into the buffer.
- digit  input  4  BCD digit from the keypad.
- op1  output  9  operand register, same format as `result`.
- sign  output  1  sign of op1 (1 = negative).
- ssdec  output  8  seven-segment pattern of the op1 ones digit.

Function
REQ-003 op1 SHALL be a 9-bit register updated only on the rising edge of clk while nrst is high.
REQ-004 Priority per cycle SHALL be result_ready > enter > store_digit > hold.
REQ-005 result_ready=1: the next op1 SHALL equal result, all 9 bits, including digit values above 9.
REQ-006 enter=1 (result_ready=0): the next op1 SHALL be 9'b0.
REQ-007 store_digit=1 (result_ready=0, enter=0, digit<=9): the next op1 SHALL be {op1[8], op1[3:0], digit}.
- The old tens digit is discarded; the sign is kept.
REQ-008 store_digit=1 with digit>9 SHALL leave op1 unchanged.
REQ-009 store_digit SHALL be level-sensitive: one shift for every clock edge it is high.
- Holding digit=1 keeps op1 at 9'b000010001 once two shifts have occurred.
REQ-010 With no control input asserted, op1 SHALL hold its value.
REQ-011 The update latency SHALL be one clock: the new op1 is visible after the rising edge that samples the control.
REQ-012 sign SHALL equal op1[8] combinationally.
REQ-013 ssdec SHALL decode op1[3:0] combinationally.
- ssdec[6:0] = {g,f,e,d,c,b,a}, active-high.
- ssdec[7] (decimal point) SHALL always be 0.
- 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
- Values 10-15 SHALL produce 0x00 (blank).
REQ-014 Simultaneous controls SHALL follow REQ-004 only; lower-priority requests in the same cycle are dropped, not queued.

Reset
REQ-015 nrst=0 SHALL immediately and asynchronously force op1 to 9'b0, so sign=0 and ssdec=0x3F.
REQ-016 While nrst=0, all inputs SHALL be ignored.
REQ-017 Release of nrst SHALL take effect at the next rising clock edge.
REQ-018 A reset asserted mid-operation SHALL discard any partially entered operand.

Verification
REQ-019 The bench SHALL cover these directed scenarios, with inputs applied at the falling edge and checked at the next falling edge:
- Reset held two cycles, then released -> op1=9'b000000000, sign=0, ssdec=0x3F.
- After reset, result_ready=1, result=9'b100110010 -> one cycle later op1=9'b100110010, sign=1, ssdec=0x5B.
- After reset, enter=1 -> op1=0; after preloading 0x32 via result_ready, enter=1 -> op1=0 the next cycle.
- After reset, store_digit=1, digit=1 -> op1=9'b000000001 after one edge and 9'b000010001 after the second; holding them longer -> op1 stays 9'b000010001.
- After reset with no stimulus -> op1 stays 0; store_digit=1 with digit=4'hA -> op1 unchanged.
- result_ready=1 and enter=1 together with result=9'h045 -> op1=9'h045; digit=7 stored into op1=9'h145 -> op1=9'h157.
